// File: rtl/conv_mac_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_engine_pkg
// Description : Shared state encodings and constant helper functions for the
//               sequenced convolution engine.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_mac_engine_pkg;

  // FSM state encodings, kept as plain constants for legacy tool flows
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_STORE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_unit
// Description : Registered unsigned multiply-accumulate with synchronous
//               clear (priority over enable) and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    acc_q;

  // Next accumulator value: clear wins, otherwise add the zero-extended product
  always_comb begin
    prod  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule
`default_nettype wire

// File: rtl/conv_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_engine
// Description : Sequenced convolution engine. One MAC per cycle over each
//               filter window, results written to an addressable buffer,
//               with start/busy/done handshake, saturation and sticky ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_engine
  import conv_mac_engine_pkg::*;
#(
  parameter  int IN_DIM  = 4,
  parameter  int K_DIM   = 3,
  parameter  int DATA_W  = 8,
  parameter  int OUT_W   = 8,
  parameter  int ACC_W   = 20,
  localparam int OUT_DIM = IN_DIM - K_DIM + 1,
  localparam int N_OUT   = OUT_DIM * OUT_DIM,
  localparam int AW      = max_int(1, clog2(N_OUT))
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             sat_en,
  input  logic [IN_DIM*IN_DIM*DATA_W-1:0]  in_flat,
  input  logic [K_DIM*K_DIM*DATA_W-1:0]    filt_flat,
  input  logic [AW-1:0]                    rd_addr,
  output logic [OUT_W-1:0]                 rd_data,
  output logic                             busy,
  output logic                             done,
  output logic                             ovf
);

  localparam int KW = max_int(1, clog2(K_DIM));
  localparam int OW = max_int(1, clog2(OUT_DIM));
  localparam logic [KW-1:0]    K_LAST   = KW'(K_DIM - 1);
  localparam logic [OW-1:0]    O_LAST   = OW'(OUT_DIM - 1);
  localparam logic [AW-1:0]    IDX_LAST = AW'(N_OUT - 1);
  localparam logic [ACC_W-1:0] OUT_MAX  = ACC_W'((64'd1 << OUT_W) - 64'd1);

  logic [2:0]                        state_q, state_d;
  logic [IN_DIM*IN_DIM*DATA_W-1:0]   in_q, in_d;
  logic [K_DIM*K_DIM*DATA_W-1:0]     filt_q, filt_d;
  logic                              sat_q, sat_d;
  logic                              ovf_q, ovf_d;
  logic [KW-1:0]                     kr_q, kr_d, kc_q, kc_d;
  logic [OW-1:0]                     orow_q, orow_d, ocol_q, ocol_d;
  logic [AW-1:0]                     idx_q, idx_d;
  logic [OUT_W-1:0]                  buf_q [N_OUT];
  logic [OUT_W-1:0]                  buf_d [N_OUT];

  logic                              mac_clr, mac_en;
  logic [DATA_W-1:0]                 in_sel, filt_sel;
  logic [ACC_W-1:0]                  acc;
  logic                              acc_big;
  logic [OUT_W-1:0]                  store_val;

  // Select the current input/filter taps from the snapshot registers
  always_comb begin
    in_sel   = '0;
    filt_sel = '0;
    for (int r = 0; r < IN_DIM; r++) begin
      for (int c = 0; c < IN_DIM; c++) begin
        if ((r == int'(orow_q) + int'(kr_q)) && (c == int'(ocol_q) + int'(kc_q)))
          in_sel = in_q[(r*IN_DIM+c)*DATA_W +: DATA_W];
      end
    end
    for (int r = 0; r < K_DIM; r++) begin
      for (int c = 0; c < K_DIM; c++) begin
        if ((r == int'(kr_q)) && (c == int'(kc_q)))
          filt_sel = filt_q[(r*K_DIM+c)*DATA_W +: DATA_W];
      end
    end
  end

  conv_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (in_sel),
    .b   (filt_sel),
    .acc (acc)
  );

  // Saturate or truncate the finished accumulation
  always_comb begin
    acc_big   = (acc > OUT_MAX);
    store_val = (sat_q && acc_big) ? '1 : acc[OUT_W-1:0];
  end

  // Sequencer: next-state, counters, snapshot and buffer write
  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    filt_d  = filt_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        in_d    = in_flat;
        filt_d  = filt_flat;
        sat_d   = sat_en;
        ovf_d   = 1'b0;
        idx_d   = '0;
        orow_d  = '0;
        ocol_d  = '0;
        kr_d    = '0;
        kc_d    = '0;
        mac_clr = 1'b1;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (kc_q == K_LAST) begin
          kc_d = '0;
          if (kr_q == K_LAST) begin
            kr_d    = '0;
            state_d = ST_STORE;
          end else begin
            kr_d = kr_q + KW'(1);
          end
        end else begin
          kc_d = kc_q + KW'(1);
        end
      end
      ST_STORE: begin
        mac_clr = 1'b1;
        if (acc_big) ovf_d = 1'b1;
        for (int i = 0; i < N_OUT; i++) begin
          if (int'(idx_q) == i) buf_d[i] = store_val;
        end
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_MAC;
          if (ocol_q == O_LAST) begin
            ocol_d = '0;
            orow_d = orow_q + OW'(1);
          end else begin
            ocol_d = ocol_q + OW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, snapshot and result registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      in_q    <= '0;
      filt_q  <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      kr_q    <= '0;
      kc_q    <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      idx_q   <= '0;
      for (int i = 0; i < N_OUT; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      filt_q  <= filt_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  // Combinational buffer read; out-of-range addresses return zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (int'(rd_addr) == i) rd_data = buf_q[i];
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_mac_engine
// Description : Directed self-checking bench for conv_mac_engine (4x4/3x3
//               default instance and a 5x5/3x3 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_mac_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sat_en = 1'b0;
  logic [127:0] in_flat = '0;
  logic [71:0]  filt_flat = '0;
  logic [1:0]   rd_addr = '0;
  logic [7:0]   rd_data;
  logic         busy, done, ovf;

  logic         start5 = 1'b0;
  logic [199:0] in_flat5 = '0;
  logic [71:0]  filt_flat5 = '0;
  logic [3:0]   rd_addr5 = '0;
  logic [7:0]   rd_data5;
  logic         busy5, done5, ovf5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_mac_engine dut (
    .clk (clk), .rst (rst), .start (start), .sat_en (sat_en),
    .in_flat (in_flat), .filt_flat (filt_flat), .rd_addr (rd_addr),
    .rd_data (rd_data), .busy (busy), .done (done), .ovf (ovf)
  );

  conv_mac_engine #(.IN_DIM(5), .K_DIM(3)) dut5 (
    .clk (clk), .rst (rst), .start (start5), .sat_en (1'b0),
    .in_flat (in_flat5), .filt_flat (filt_flat5), .rd_addr (rd_addr5),
    .rd_data (rd_data5), .busy (busy5), .done (done5), .ovf (ovf5)
  );

  task automatic set_ramp();
    for (int i = 0; i < 16; i++) in_flat[i*8 +: 8] = 8'(i + 1);
  endtask

  task automatic set_ones();
    for (int i = 0; i < 9; i++) filt_flat[i*8 +: 8] = 8'd1;
  endtask

  // Pulse start for one edge and count edges until done is seen
  task automatic do_run(input logic sat, output int edges);
    sat_en = sat;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd[%0d] got %0d want 0", i, rd_data); end
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int edges;
    int exp_v[4] = '{54, 63, 90, 99};
    set_ramp(); set_ones();
    do_run(1'b0, edges);
    checks++; if (edges !== 41) begin errors++; $display("FAIL basic_latency got %0d want 41", edges); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", ovf); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++; if (rd_data !== 8'(exp_v[i])) begin errors++; $display("FAIL basic_rd[%0d] got %0d want %0d", i, rd_data, exp_v[i]); end
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_identity();
    int edges;
    int exp_v[4] = '{6, 7, 10, 11};
    set_ramp();
    filt_flat = '0;
    filt_flat[4*8 +: 8] = 8'd1;
    do_run(1'b0, edges);
    checks++; if (edges !== 41) begin errors++; $display("FAIL ident_latency got %0d want 41", edges); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++; if (rd_data !== 8'(exp_v[i])) begin errors++; $display("FAIL ident_rd[%0d] got %0d want %0d", i, rd_data, exp_v[i]); end
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ident_busy_after got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    int edges;
    in_flat = '1; filt_flat = '1;
    do_run(1'b1, edges);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sat_flag got %b want 1", ovf); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++; if (rd_data !== 8'd255) begin errors++; $display("FAIL ovf_sat_rd[%0d] got %0d want 255", i, rd_data); end
    end
    @(posedge clk); #1;
    do_run(1'b0, edges);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_trunc_flag got %b want 1", ovf); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++; if (rd_data !== 8'd9) begin errors++; $display("FAIL ovf_trunc_rd[%0d] got %0d want 9", i, rd_data); end
    end
    @(posedge clk); #1;
    set_ramp(); set_ones();
    do_run(1'b0, edges);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf); end
    rd_addr = 2'd3; #1;
    checks++; if (rd_data !== 8'd99) begin errors++; $display("FAIL ovf_clear_rd3 got %0d want 99", rd_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int exp_v[4] = '{54, 63, 90, 99};
    set_ramp(); set_ones();
    sat_en = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (n == 3) in_flat = {16{8'hAA}};
      start = (n >= 5 && n <= 30);
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++; if (rd_data !== 8'(exp_v[i])) begin errors++; $display("FAIL b2b_rd[%0d] got %0d want %0d", i, rd_data, exp_v[i]); end
    end
  endtask

  task automatic test_midrun_reset();
    int edges;
    // Leave an overflowed run in the buffer so the reset has something to clear
    in_flat = '1; filt_flat = '1;
    do_run(1'b1, edges);
    @(posedge clk); #1;
    sat_en = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL rst_ovf got %b want 0", ovf); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL rst_rd[%0d] got %0d want 0", i, rd_data); end
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    set_ramp(); set_ones();
    do_run(1'b0, edges);
    checks++; if (edges !== 41) begin errors++; $display("FAIL rst_rerun_latency got %0d want 41", edges); end
    rd_addr = 2'd0; #1;
    checks++; if (rd_data !== 8'd54) begin errors++; $display("FAIL rst_rerun_rd0 got %0d want 54", rd_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_dim5();
    int edges;
    int exp_v[9] = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
    for (int i = 0; i < 25; i++) in_flat5[i*8 +: 8] = 8'(i + 1);
    for (int i = 0; i < 9; i++)  filt_flat5[i*8 +: 8] = 8'd1;
    start5 = 1'b1;
    @(posedge clk);
    #1 start5 = 1'b0;
    edges = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (done5) begin
        edges = n;
        break;
      end
    end
    checks++; if (edges !== 91) begin errors++; $display("FAIL dim5_latency got %0d want 91", edges); end
    for (int i = 0; i < 9; i++) begin
      rd_addr5 = 4'(i); #1;
      checks++; if (rd_data5 !== 8'(exp_v[i])) begin errors++; $display("FAIL dim5_rd[%0d] got %0d want %0d", i, rd_data5, exp_v[i]); end
    end
    for (int i = 9; i < 16; i += 6) begin
      rd_addr5 = 4'(i); #1;
      checks++; if (rd_data5 !== 8'd0) begin errors++; $display("FAIL dim5_oob[%0d] got %0d want 0", i, rd_data5); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_identity();
    test_overflow();
    test_back_to_back();
    test_midrun_reset();
    test_dim5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_mac_engine.md
Name: conv_mac_engine

Overview:
Parametrised convolution engine for the next-generation accelerator top. It replaces the fixed 4x4-input / 3x3-filter / 2x2-output arrays with a single sequenced MAC datapath. Input and filter are supplied as flat buses from memory, and results land in an internal result buffer that display/readout logic reads by address. It adds start/busy/done handshaking, a run-time saturation mode and a sticky overflow flag; the fixed arrays have none of these.

Parameters:
IN_DIM, 4, input matrix side length (>=K_DIM)
K_DIM, 3, filter side length (>=1)
DATA_W, 8, unsigned width of input and filter elements
OUT_W, 8, unsigned width of stored results
ACC_W, 20, accumulator width; must be >= 2*DATA_W + clog2(K_DIM*K_DIM)
Derived: OUT_DIM = IN_DIM-K_DIM+1; N_OUT = OUT_DIM*OUT_DIM; AW = max(1, clog2(N_OUT))

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a run; accepted only in IDLE
sat_en  in  1  1 = saturate results to OUT_W, 0 = truncate; sampled with start
in_flat  in  IN_DIM*IN_DIM*DATA_W  element (r,c) at bits [(r*IN_DIM+c)*DATA_W +: DATA_W]
filt_flat  in  K_DIM*K_DIM*DATA_W  element (r,c) at bits [(r*K_DIM+c)*DATA_W +: DATA_W]
rd_addr  in  AW  result index, r*OUT_DIM+c
rd_data  out  OUT_W  combinational read of result buffer[rd_addr]; 0 if rd_addr >= N_OUT
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at run completion
ovf  out  1  sticky: some result of the current/last run exceeded OUT_W

Behaviour:
- Clock/reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, ovf=0, all result buffer entries=0, accumulator=0, counters=0.
- FSM states: IDLE, LOAD, MAC, STORE, DONE.
  - IDLE -> LOAD on a clk edge with start=1.
  - LOAD (1 cycle): snapshot in_flat, filt_flat and sat_en into internal registers. Later input changes do not affect the run. Clear ovf. Reset output index to 0.
  - MAC (K_DIM*K_DIM cycles per output): each cycle acc += in[orow+kr][ocol+kc] * filt[kr][kc]. Scan kr, kc in row-major order. acc is cleared on MAC entry.
  - STORE (1 cycle): write the result to buffer[idx].
    - If acc > 2^OUT_W-1, set ovf=1.
    - The stored value is all-ones when sat is on, else acc[OUT_W-1:0].
    - If idx < N_OUT-1: idx++ and go to MAC. Otherwise go to DONE.
  - DONE (1 cycle): done=1, then return to IDLE.
- Latency: with start sampled at edge E0, done is high during the cycle after edge E0+1+N_OUT*(K_DIM^2+1). busy falls at the following edge. Defaults: 41 edges after E0 (done window), i.e. 42 cycles start-to-idle.
- start while busy: ignored, with no queueing. start in DONE cycle: ignored. start held high in IDLE: a new run begins each time IDLE is reached.
- Result buffer:
  - Holds the previous run's values until each entry is overwritten in STORE.
  - A read of an entry being written in the same cycle returns the old value.
  - The buffer is not cleared by start.
- All arithmetic is unsigned. Products are DATA_W*2 bits and are zero-extended into ACC_W. ACC_W is sized so the accumulator cannot wrap.
- rst mid-run: immediate return to reset values, including the buffer. No done pulse is produced.

Decomposition:
- Shared header conv_defs.vh holds:
  - state encodings (IDLE=0, LOAD=1, MAC=2, STORE=3, DONE=4, 3 bits);
  - the clog2 function;
  - the derived-dimension localparam formulas, reused by the display and memory blocks.
- One sub-module, conv_mac_unit: registered multiply-accumulate with synchronous clear and enable, plus async rst. Parameters DATA_W and ACC_W.

Test Plan:
- Basic run: defaults, in_flat = ramp 1..16 row-major, filter all ones, sat_en=0, start pulse. Required:
  - rd_data[0..3] = 54, 63, 90, 99;
  - done pulse exactly 41 edges after the start edge;
  - ovf=0.
- Identity filter (center=1, others 0), same ramp -> results 6, 7, 10, 11; busy low after done.
- Overflow, all inputs and filters 255:
  - sat_en=1 -> all results 255, ovf=1;
  - rerun with sat_en=0 -> all results 9 (585225 mod 256), ovf=1.
  - Then run the ramp case -> ovf clears to 0.
- start asserted repeatedly mid-run -> exactly one done pulse; results unchanged from the single-run case. Changing in_flat after LOAD does not affect results.
- rst asserted asynchronously at cycle 20 of a run -> busy=0, done=0, ovf=0, all rd_data=0 immediately. A subsequent run completes normally.
- IN_DIM=5, K_DIM=3, ramp 1..25, all-ones filter -> N_OUT=9, done at edge E0+91; results 63, 72, 81, 108, 117, 126, 153, 162, 171; rd_addr >= 9 reads 0.
